wb_stage: RTL and testbench

Writeback stage placed directly upstream of the 32x32 register file; it is the only block that drives the file's write port. It accepts one retiring instruction at a time from execute over a valid/ready handshake. ALU results are committed directly. Loads issue a word read to data memory, then extract, extend and commit the returned data. Writes to x0 are suppressed here and again inside the register file.

---
 rtl/wb_stage_if.sv | 38 +++
 rtl/wb_stage.sv | 146 ++++++++++++++
 tb/tb_wb_stage.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// Bus bundle for the writeback stage: execute handshake, data-memory read port
// and register-file write port.
interface wb_stage_if #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] in_rd;
   logic                  in_rd_wen;
   logic                  in_is_load;
   logic [2:0]            in_funct3;
   logic [DATA_WIDTH-1:0] in_result;
   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic [DATA_WIDTH-1:0] mem_req_addr;
   logic                  mem_rsp_valid;
   logic [DATA_WIDTH-1:0] mem_rsp_data;
   logic                  rf_wen;
   logic [ADDR_WIDTH-1:0] rf_waddr;
   logic [DATA_WIDTH-1:0] rf_wdata;
   logic                  commit;
   logic                  ld_fault;

   modport slave (
      input  in_valid, in_rd, in_rd_wen, in_is_load, in_funct3, in_result,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
      output in_ready, mem_req_valid, mem_req_addr,
      output rf_wen, rf_waddr, rf_wdata, commit, ld_fault
   );

   modport master (
      output in_valid, in_rd, in_rd_wen, in_is_load, in_funct3, in_result,
      output mem_req_ready, mem_rsp_valid, mem_rsp_data,
      input  in_ready, mem_req_valid, mem_req_addr,
      input  rf_wen, rf_waddr, rf_wdata, commit, ld_fault
   );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results directly, performs word reads for loads
// with byte/half extraction, and owns the register-file write port.
module wb_stage #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic        clk,
   input  logic        rst,
   wb_stage_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_REQ  = 2'd1,
      MEM_WAIT = 2'd2,
      COMMIT   = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] rd_q;
   logic                  rd_wen_q;
   logic [2:0]            funct3_q;
   logic [DATA_WIDTH-1:0] result_q;

   logic                  rf_wen_q, commit_q, ld_fault_q;
   logic [ADDR_WIDTH-1:0] rf_waddr_q;
   logic [DATA_WIDTH-1:0] rf_wdata_q;

   logic                  accept;
   logic                  fault_in;
   logic                  wen_d;
   logic                  fault_d;
   logic [ADDR_WIDTH-1:0] waddr_d;
   logic [DATA_WIDTH-1:0] wdata_d;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [DATA_WIDTH-1:0] ld_value;

   assign accept = bus.in_valid && (state_q == IDLE);

   // Fault check runs on the incoming instruction so a bad load never leaves IDLE
   // for the memory states.
   always_comb begin
      fault_in = 1'b0;
      unique case (bus.in_funct3)
         3'b000, 3'b100: fault_in = 1'b0;
         3'b001, 3'b101: fault_in = bus.in_result[0];
         3'b010:         fault_in = (bus.in_result[1:0] != 2'b00);
         default:        fault_in = 1'b1;
      endcase
   end

   always_comb begin
      ld_byte = bus.mem_rsp_data[7:0];
      unique case (result_q[1:0])
         2'd0: ld_byte = bus.mem_rsp_data[7:0];
         2'd1: ld_byte = bus.mem_rsp_data[15:8];
         2'd2: ld_byte = bus.mem_rsp_data[23:16];
         2'd3: ld_byte = bus.mem_rsp_data[31:24];
         default: ld_byte = bus.mem_rsp_data[7:0];
      endcase
      ld_half = result_q[1] ? bus.mem_rsp_data[31:16] : bus.mem_rsp_data[15:0];
      unique case (funct3_q)
         3'b000:  ld_value = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
         3'b001:  ld_value = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
         3'b100:  ld_value = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
         3'b101:  ld_value = {{(DATA_WIDTH-16){1'b0}}, ld_half};
         default: ld_value = bus.mem_rsp_data;
      endcase
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (accept) state_d = (bus.in_is_load && !fault_in) ? MEM_REQ : COMMIT;
         MEM_REQ:  if (bus.mem_req_ready) state_d = bus.mem_rsp_valid ? COMMIT : MEM_WAIT;
         MEM_WAIT: if (bus.mem_rsp_valid) state_d = COMMIT;
         COMMIT:   state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      bus.in_ready      = (state_q == IDLE);
      bus.mem_req_valid = (state_q == MEM_REQ);
      bus.mem_req_addr  = {result_q[DATA_WIDTH-1:2], 2'b00};
      bus.rf_wen        = rf_wen_q;
      bus.rf_waddr      = rf_waddr_q;
      bus.rf_wdata      = rf_wdata_q;
      bus.commit        = commit_q;
      bus.ld_fault      = ld_fault_q;
   end

   // Commit values are formed from the live inputs when coming straight from IDLE,
   // otherwise from the latched fields and the memory response.
   always_comb begin
      if (state_q == IDLE) begin
         fault_d = bus.in_is_load && fault_in;
         wen_d   = bus.in_rd_wen && (bus.in_rd != '0) && !fault_d;
         waddr_d = bus.in_rd;
         wdata_d = bus.in_result;
      end else begin
         fault_d = 1'b0;
         wen_d   = rd_wen_q && (rd_q != '0);
         waddr_d = rd_q;
         wdata_d = ld_value;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         rd_q       <= '0;
         rd_wen_q   <= 1'b0;
         funct3_q   <= '0;
         result_q   <= '0;
         rf_wen_q   <= 1'b0;
         commit_q   <= 1'b0;
         ld_fault_q <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            rd_q     <= bus.in_rd;
            rd_wen_q <= bus.in_rd_wen;
            funct3_q <= bus.in_funct3;
            result_q <= bus.in_result;
         end
         if (state_d == COMMIT) begin
            rf_wen_q   <= wen_d;
            commit_q   <= 1'b1;
            ld_fault_q <= fault_d;
            rf_waddr_q <= waddr_d;
            rf_wdata_q <= wdata_d;
         end else begin
            rf_wen_q   <= 1'b0;
            commit_q   <= 1'b0;
            ld_fault_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU commits, load extraction, faults, memory
// stalls and asynchronous reset in the middle of a load.
module tb_wb_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   wb_stage_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

   wb_stage #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [4:0] rd, input logic wen, input logic ld,
                          input logic [2:0] f3, input logic [31:0] res);
      bus.in_valid   = 1'b1;
      bus.in_rd      = rd;
      bus.in_rd_wen  = wen;
      bus.in_is_load = ld;
      bus.in_funct3  = f3;
      bus.in_result  = res;
   endtask

   // Load with zero-wait memory: ready in N+1, response in N+2, commit in N+3.
   task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] word,
                          input logic [31:0] exp);
      present(rd, 1'b1, 1'b1, f3, addr);
      tick();
      bus.in_valid = 1'b0;
      chk({tag, "_req_valid"}, bus.mem_req_valid, 1);
      chk({tag, "_req_addr"}, bus.mem_req_addr, {addr[31:2], 2'b00});
      bus.mem_req_ready = 1'b1;
      tick();
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = word;
      chk({tag, "_wait_nocommit"}, bus.commit, 0);
      tick();
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;
      chk({tag, "_wen"}, bus.rf_wen, 1);
      chk({tag, "_waddr"}, bus.rf_waddr, rd);
      chk({tag, "_wdata"}, bus.rf_wdata, exp);
      chk({tag, "_commit"}, {bus.commit, bus.ld_fault}, 2'b10);
      tick();
      chk({tag, "_idle"}, {bus.in_ready, bus.commit}, 2'b10);
   endtask

   task automatic do_fault(input string tag, input logic [2:0] f3, input logic [31:0] addr);
      present(5'd7, 1'b1, 1'b1, f3, addr);
      tick();
      bus.in_valid = 1'b0;
      chk({tag, "_commit"}, bus.commit, 1);
      chk({tag, "_ld_fault"}, bus.ld_fault, 1);
      chk({tag, "_wen"}, bus.rf_wen, 0);
      chk({tag, "_noreq"}, bus.mem_req_valid, 0);
      tick();
      chk({tag, "_after"}, {bus.in_ready, bus.commit, bus.ld_fault, bus.mem_req_valid}, 4'b1000);
   endtask

   initial begin
      bus.in_valid      = 1'b0;
      bus.in_rd         = '0;
      bus.in_rd_wen     = 1'b0;
      bus.in_is_load    = 1'b0;
      bus.in_funct3     = '0;
      bus.in_result     = '0;
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;

      tick();
      tick();
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_outs", {bus.rf_wen, bus.commit, bus.ld_fault, bus.mem_req_valid}, 4'b0000);
      chk("rst_waddr", bus.rf_waddr, 0);
      chk("rst_wdata", bus.rf_wdata, 0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_quiet", {bus.in_ready, bus.rf_wen, bus.commit, bus.mem_req_valid}, 4'b1000);
      end

      // ALU op: commit one cycle after acceptance
      present(5'd5, 1'b1, 1'b0, 3'b000, 32'hDEADBEEF);
      chk("alu_ready", bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      chk("alu_wen", bus.rf_wen, 1);
      chk("alu_waddr", bus.rf_waddr, 5);
      chk("alu_wdata", bus.rf_wdata, 32'hDEADBEEF);
      chk("alu_commit", {bus.commit, bus.ld_fault, bus.in_ready}, 3'b100);
      tick();
      chk("alu_back_idle", {bus.in_ready, bus.rf_wen, bus.commit}, 3'b100);
      chk("alu_wdata_hold", bus.rf_wdata, 32'hDEADBEEF);

      do_load("lb",      5'd1, 3'b000, 32'h80000003, 32'h80FF1234, 32'hFFFFFF80);
      do_load("lbu",     5'd2, 3'b100, 32'h80000003, 32'h80FF1234, 32'h00000080);
      do_load("lh",      5'd3, 3'b001, 32'h80000002, 32'h80FF1234, 32'hFFFF80FF);
      do_load("lhu_lo",  5'd4, 3'b101, 32'h80000000, 32'h80FF1234, 32'h00001234);
      do_load("lb_off1", 5'd6, 3'b000, 32'h80000001, 32'h80FF1234, 32'h00000012);
      do_load("lw",      5'd8, 3'b010, 32'h80000004, 32'h12345678, 32'h12345678);

      do_fault("lw_mis",  3'b010, 32'h80000002);
      do_fault("f3_011",  3'b011, 32'h80000000);
      do_fault("lh_mis",  3'b001, 32'h80000001);

      // Write to x0 commits without writing
      present(5'd0, 1'b1, 1'b0, 3'b000, 32'h00000055);
      tick();
      bus.in_valid = 1'b0;
      chk("x0_commit", bus.commit, 1);
      chk("x0_wen", bus.rf_wen, 0);
      tick();

      // Stalled request then delayed response; in_valid held high meanwhile
      present(5'd9, 1'b1, 1'b1, 3'b010, 32'h80000010);
      tick();
      present(5'd3, 1'b1, 1'b0, 3'b000, 32'h11111111);
      for (int i = 0; i < 4; i++) begin
         chk("stall_req", {bus.mem_req_valid, bus.in_ready}, 2'b10);
         chk("stall_addr", bus.mem_req_addr, 32'h80000010);
         tick();
      end
      bus.mem_req_ready = 1'b1;
      chk("stall_req_last", bus.mem_req_valid, 1);
      tick();
      bus.mem_req_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("stall_wait", {bus.mem_req_valid, bus.commit, bus.in_ready}, 3'b000);
         tick();
      end
      bus.in_valid      = 1'b0;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'hCAFEF00D;
      tick();
      bus.mem_rsp_valid = 1'b0;
      chk("stall_commit", {bus.commit, bus.rf_wen}, 2'b11);
      chk("stall_waddr", bus.rf_waddr, 9);
      chk("stall_wdata", bus.rf_wdata, 32'hCAFEF00D);
      tick();
      chk("stall_single", {bus.commit, bus.in_ready}, 2'b01);
      tick();
      chk("stall_no_accept", {bus.commit, bus.in_ready}, 2'b01);

      // Response in the same cycle as the request handshake skips MEM_WAIT
      present(5'd10, 1'b1, 1'b1, 3'b100, 32'h80000021);
      tick();
      bus.in_valid      = 1'b0;
      bus.mem_req_ready = 1'b1;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'h80FF1234;
      tick();
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      chk("same_commit", {bus.commit, bus.rf_wen}, 2'b11);
      chk("same_wdata", bus.rf_wdata, 32'h00000012);
      tick();

      // Reset during MEM_WAIT, then a stale response
      present(5'd11, 1'b1, 1'b1, 3'b010, 32'h80000030);
      tick();
      bus.in_valid      = 1'b0;
      bus.mem_req_ready = 1'b1;
      tick();
      bus.mem_req_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", bus.in_ready, 1);
      tick();
      rst = 1'b0;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'h77777777;
      tick();
      bus.mem_rsp_valid = 1'b0;
      chk("stale_rsp", {bus.commit, bus.rf_wen, bus.in_ready, bus.mem_req_valid}, 4'b0010);
      tick();
      chk("stale_after", {bus.commit, bus.rf_wen, bus.in_ready}, 3'b001);
      chk("stale_wdata", bus.rf_wdata, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
